cond_flag_unit: RTL

Condition-flag register and branch-condition resolver for the pipelined ARM datapath. Captures NZCV from flag-setting ALU operations, forwards newly produced flags to a same-cycle conditional branch, and issues a registered branch decision for B.cond and CBZ/CBNZ one cycle later. Sits at the EX/MEM boundary, consuming the ALU result bus and feeding the fetch redirect logic.

---
 rtl/cond_pkg.sv | 38 +++
 rtl/cond_flag_unit_if.sv | 32 +++
 rtl/cond_eval.sv | 31 +++
 rtl/zero_detect.sv | 9 +
 rtl/cond_flag_unit.sv | 75 +++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared types for condition-flag handling: ARM condition codes, branch kinds
// and the NZCV flag layout.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        BR_BCOND = 2'd0,
        BR_CBZ   = 2'd1,
        BR_CBNZ  = 2'd2,
        BR_RSVD  = 2'd3
    } br_kind_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/cond_flag_unit_if.sv
// EX/MEM-side bundle: ALU result, branch request, pipeline control and the
// registered flag/branch outputs.
interface cond_flag_unit_if #(
    parameter int WIDTH = 64
);
    logic             alu_valid;
    logic             alu_set_flags;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             br_req;
    logic [1:0]       br_kind;
    logic [3:0]       br_cond;
    logic [WIDTH-1:0] br_operand;
    logic             stall;
    logic             flush;
    logic [3:0]       flags;
    logic             br_valid;
    logic             br_taken;

    modport master (
        output alu_valid, alu_set_flags, alu_result, alu_carry, alu_overflow,
        output br_req, br_kind, br_cond, br_operand, stall, flush,
        input  flags, br_valid, br_taken
    );

    modport slave (
        input  alu_valid, alu_set_flags, alu_result, alu_carry, alu_overflow,
        input  br_req, br_kind, br_cond, br_operand, stall, flush,
        output flags, br_valid, br_taken
    );
endinterface

// File: rtl/cond_eval.sv
// ARM condition-code evaluator on a set of NZCV flags; purely combinational so
// the conditional-select path can reuse it.
module cond_eval
    import cond_pkg::*;
(
    input  nzcv_t nzcv,
    input  cond_e cond,
    output logic  taken
);
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_EQ: taken = nzcv.z;
            COND_NE: taken = ~nzcv.z;
            COND_HS: taken = nzcv.c;
            COND_LO: taken = ~nzcv.c;
            COND_MI: taken = nzcv.n;
            COND_PL: taken = ~nzcv.n;
            COND_VS: taken = nzcv.v;
            COND_VC: taken = ~nzcv.v;
            COND_HI: taken = nzcv.c & ~nzcv.z;
            COND_LS: taken = ~nzcv.c | nzcv.z;
            COND_GE: taken = (nzcv.n == nzcv.v);
            COND_LT: taken = (nzcv.n != nzcv.v);
            COND_GT: taken = ~nzcv.z & (nzcv.n == nzcv.v);
            COND_LE: taken = nzcv.z | (nzcv.n != nzcv.v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/zero_detect.sv
// WIDTH-wide zero test, shared by the Z flag and the CBZ/CBNZ operand check.
module zero_detect #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value,
    output logic             is_zero
);
    assign is_zero = ~(|value);
endmodule

// File: rtl/cond_flag_unit.sv
// NZCV register plus registered branch resolver for B.cond and CBZ/CBNZ,
// with same-cycle forwarding of freshly generated flags.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    cond_flag_unit_if.slave  bus
);
    logic  res_zero;
    logic  op_zero;
    logic  use_new;
    logic  req_live;
    logic  cond_taken;
    logic  decision;
    nzcv_t gen_nzcv;
    nzcv_t eff_nzcv;
    nzcv_t flags_q;
    logic  br_valid_q;
    logic  br_taken_q;

    zero_detect #(.WIDTH(WIDTH)) u_zero_result (
        .value   (bus.alu_result),
        .is_zero (res_zero)
    );

    zero_detect #(.WIDTH(WIDTH)) u_zero_operand (
        .value   (bus.br_operand),
        .is_zero (op_zero)
    );

    assign gen_nzcv = '{n: bus.alu_result[WIDTH-1], z: res_zero,
                        c: bus.alu_carry, v: bus.alu_overflow};

    // A flag-setter in the same cycle is older than the branch, so its flags win.
    assign use_new  = bus.alu_valid & bus.alu_set_flags & ~bus.flush;
    assign eff_nzcv = use_new ? gen_nzcv : flags_q;
    assign req_live = bus.br_req & ~bus.flush;

    cond_eval u_cond_eval (
        .nzcv  (eff_nzcv),
        .cond  (cond_e'(bus.br_cond)),
        .taken (cond_taken)
    );

    always_comb begin
        decision = 1'b0;
        unique case (br_kind_e'(bus.br_kind))
            BR_BCOND: decision = cond_taken;
            BR_CBZ:   decision = op_zero;
            BR_CBNZ:  decision = ~op_zero;
            default:  decision = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= '0;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
        end else if (!bus.stall) begin
            if (use_new) begin
                flags_q <= gen_nzcv;
            end
            br_valid_q <= req_live;
            br_taken_q <= req_live & decision;
        end
    end

    assign bus.flags    = flags_q;
    assign bus.br_valid = br_valid_q;
    assign bus.br_taken = br_taken_q;
endmodule
